ntt_butterfly_dual: RTL and testbench

Parametrised radix-2 NTT/INTT butterfly for the Kyber datapath. Each sample selects its own mode: Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT).
- Fixed-latency, fully pipelined; one butterfly per enabled cycle.
- The per-sample mode and a sideband tag travel with the data, so the control FSM can interleave forward and inverse operations back-to-back.
- Flags input operands that are out of range.

---
 rtl/ntt_butterfly_dual.sv | 155 +++++++++++++++
 tb/tb_ntt_butterfly_dual.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_dual.sv
// Dual-mode radix-2 NTT butterfly (CT forward / GS inverse per sample), latency MUL_STAGES+2.
// Define INTT_HALVE_EN to scale GS results by 2^-1 mod q in the output stage.
module ntt_butterfly_dual #(
  parameter int DATA_WIDTH = 12,
  parameter int MODULUS    = 3329,
  parameter int MUL_STAGES = 3,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clr_err,
  input  logic                  valid_in,
  input  logic                  mode_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] twiddle,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  mode_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  range_err
);
  localparam int W = DATA_WIDTH;
  localparam int K = 2 * DATA_WIDTH;
  localparam int L = MUL_STAGES + 2;
  localparam logic [W:0]   Q1   = (W+1)'(MODULUS);
  localparam logic [K-1:0] QK   = K'(MODULUS);
  localparam logic [63:0]  BM64 = (64'd1 << K) / 64'(MODULUS);
  localparam logic [K-1:0] BM   = BM64[K-1:0];

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q1) s = s - Q1;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) d = d + Q1;
    return d[W-1:0];
  endfunction

  // Barrett with k = 2W: for x < 2^k the quotient estimate is short by at most 1.
  function automatic logic [W-1:0] mod_red(input logic [K-1:0] x);
    logic [2*K-1:0] xm;
    logic [K-1:0]   t, r;
    xm = {{K{1'b0}}, x} * {{K{1'b0}}, BM};
    t  = xm[2*K-1:K];
    r  = x - t * QK;
    if (r >= QK) r = r - QK;
    return r[W-1:0];
  endfunction

`ifdef INTT_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] v);
    logic [W:0] s;
    s = v[0] ? ({1'b0, v} + Q1) : {1'b0, v};
    return s[W:1];
  endfunction
`endif

  // stage 0: pre (GS add/sub), stages 1..MUL_STAGES: multiplier, stage L-1: output
  logic [L-1:0]                vld_pipe, mode_pipe;
  logic [L-1:0][TAG_WIDTH-1:0] tag_pipe;
  logic [W-1:0]                x0, y0, w0, p_q;
  logic [MUL_STAGES-1:0][W-1:0] x_d;
  logic [K-1:0]                prod0;
  logic                        bad_in;
  logic [W-1:0]                ra, rb;

  assign prod0  = {{W{1'b0}}, y0} * {{W{1'b0}}, w0};
  assign bad_in = ({1'b0, a_in} >= Q1) || ({1'b0, b_in} >= Q1) || ({1'b0, twiddle} >= Q1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
      tag_pipe  <= '0;
      x0        <= '0;
      y0        <= '0;
      w0        <= '0;
      x_d       <= '0;
      range_err <= 1'b0;
    end else if (enable) begin
      vld_pipe  <= {vld_pipe[L-2:0], valid_in};
      mode_pipe <= {mode_pipe[L-2:0], mode_in};
      tag_pipe  <= {tag_pipe[L-2:0], tag_in};
      x0        <= mode_in ? mod_add(a_in, b_in) : a_in;
      y0        <= mode_in ? mod_sub(a_in, b_in) : b_in;
      w0        <= twiddle;
      x_d[0]    <= x0;
      for (int i = 1; i < MUL_STAGES; i++) x_d[i] <= x_d[i-1];
      if (valid_in && bad_in) range_err <= 1'b1;
      else if (clr_err)       range_err <= 1'b0;
    end
  end

  // Product is carried raw through the early stages; reduction lands in the last one.
  generate
    if (MUL_STAGES == 1) begin : g_mul1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      p_q <= '0;
        else if (enable) p_q <= mod_red(prod0);
      end
    end else begin : g_muln
      logic [MUL_STAGES-2:0][K-1:0] prod_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_q <= '0;
          p_q    <= '0;
        end else if (enable) begin
          prod_q[0] <= prod0;
          for (int i = 1; i < MUL_STAGES - 1; i++) prod_q[i] <= prod_q[i-1];
          p_q <= mod_red(prod_q[MUL_STAGES-2]);
        end
      end
    end
  endgenerate

  always_comb begin
    ra = mod_add(x_d[MUL_STAGES-1], p_q);
    rb = mod_sub(x_d[MUL_STAGES-1], p_q);
    if (mode_pipe[MUL_STAGES]) begin
`ifdef INTT_HALVE_EN
      ra = halve(x_d[MUL_STAGES-1]);
      rb = halve(p_q);
`else
      ra = x_d[MUL_STAGES-1];
      rb = p_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
    end else if (enable) begin
      a_out <= ra;
      b_out <= rb;
    end
  end

  assign valid_out = vld_pipe[L-1];
  assign mode_out  = mode_pipe[L-1];
  assign tag_out   = tag_pipe[L-1];
  assign busy      = |vld_pipe;

endmodule

// File: tb/tb_ntt_butterfly_dual.sv
// Directed bench for ntt_butterfly_dual: single vectors, wrap cases, streaming with stall, range_err, reset.
module tb_ntt_butterfly_dual;
  localparam int Q = 3329;
  localparam int L = 5;

  logic        clk = 1'b0;
  logic        rst_n, enable, clr_err, valid_in, mode_in;
  logic [7:0]  tag_in;
  logic [11:0] a_in, b_in, twiddle;
  logic [11:0] a_out, b_out;
  logic [7:0]  tag_out;
  logic        mode_out, valid_out, busy, range_err;

  int vectors = 0;
  int errs    = 0;

  ntt_butterfly_dual #(.DATA_WIDTH(12), .MODULUS(Q), .MUL_STAGES(3), .TAG_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
    .valid_in(valid_in), .mode_in(mode_in), .tag_in(tag_in),
    .a_in(a_in), .b_in(b_in), .twiddle(twiddle),
    .a_out(a_out), .b_out(b_out), .tag_out(tag_out), .mode_out(mode_out),
    .valid_out(valid_out), .busy(busy), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic int half(input int x);
    return (x % 2 == 1) ? (x + Q) / 2 : x / 2;
  endfunction

  // Reference: plain integer arithmetic with the % operator.
  task automatic model(input logic m, input int a, input int b, input int w,
                       output int ea, output int eb);
    int p;
    if (!m) begin
      p  = (b * w) % Q;
      ea = (a + p) % Q;
      eb = (a - p + Q) % Q;
    end else begin
      ea = (a + b) % Q;
      eb = (((a - b + Q) % Q) * w) % Q;
`ifdef INTT_HALVE_EN
      ea = half(ea);
      eb = half(eb);
`endif
    end
  endtask

  task automatic run_one(input string name, input logic m, input logic [7:0] tg,
                         input int a, input int b, input int w, input int ea, input int eb);
    valid_in = 1'b1; mode_in = m; tag_in = tg;
    a_in = 12'(a); b_in = 12'(b); twiddle = 12'(w);
    tick();
    valid_in = 1'b0;
    check({name, "_busy"}, 32'(busy), 1);
    repeat (L - 2) tick();
    check({name, "_early"}, 32'(valid_out), 0);
    tick();
    check({name, "_valid"}, 32'(valid_out), 1);
    check({name, "_a"}, 32'(a_out), 32'(ea));
    check({name, "_b"}, 32'(b_out), 32'(eb));
    check({name, "_tag"}, 32'(tag_out), 32'(tg));
    check({name, "_mode"}, 32'(mode_out), 32'(m));
    tick();
    check({name, "_pulse"}, 32'(valid_out), 0);
  endtask

  int sa[8], sb[8], sw[8];

  initial begin
    int ea, eb, sent, got;
    logic en, adv;
    logic [24:0] snap;

    rst_n = 1'b0; enable = 1'b1; clr_err = 1'b0; valid_in = 1'b0; mode_in = 1'b0;
    tag_in = '0; a_in = '0; b_in = '0; twiddle = '0;
    #12;
    check("rst_valid", 32'(valid_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(range_err), 0);
    check("rst_a", 32'(a_out), 0);
    check("rst_b", 32'(b_out), 0);
    rst_n = 1'b1;
    tick();

    run_one("ct_basic", 1'b0, 8'h3C, 100, 200, 17, 171, 29);
`ifdef INTT_HALVE_EN
    run_one("gs_basic", 1'b1, 8'hA5, 100, 200, 17, 150, 2479);
    run_one("gs_wrap", 1'b1, 8'h11, 0, 1, 1, 1665, 1664);
`else
    run_one("gs_basic", 1'b1, 8'hA5, 100, 200, 17, 300, 1629);
    run_one("gs_wrap", 1'b1, 8'h11, 0, 1, 1, 1, 3328);
`endif
    run_one("ct_wrap", 1'b0, 8'h22, 3328, 1, 1, 0, 3327);

    // Streaming: 8 alternating samples, enable low for 3 cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      sa[i] = (i * 911 + 5) % Q;
      sb[i] = 3328 - i * 433;
      sw[i] = (17 + i * 401) % Q;
    end
    sent = 0; got = 0;
    for (int c = 0; c < 24; c++) begin
      en = !(c >= 4 && c < 7);
      enable = en;
      if (en && valid_out) begin
        if (got < 8) begin
          model(got[0], sa[got], sb[got], sw[got], ea, eb);
          check("stream_a", 32'(a_out), 32'(ea));
          check("stream_b", 32'(b_out), 32'(eb));
          check("stream_tag", 32'(tag_out), 32'(got));
          check("stream_mode", 32'(mode_out), 32'(got[0]));
        end
        got++;
      end
      adv = en && (sent < 8);
      if (sent < 8) begin
        valid_in = 1'b1; mode_in = sent[0]; tag_in = 8'(sent);
        a_in = 12'(sa[sent]); b_in = 12'(sb[sent]); twiddle = 12'(sw[sent]);
      end else begin
        valid_in = 1'b0;
      end
      snap = {a_out, b_out, valid_out};
      tick();
      if (!en) begin
        check("stall_hold", 32'({a_out, b_out, valid_out}), 32'(snap));
        check("stall_busy", 32'(busy), 1);
      end
      if (adv) sent++;
    end
    enable = 1'b1;
    check("stream_count", 32'(got), 8);
    check("stream_idle", 32'(busy), 0);

    // range_err: boundary q-1 is legal, invalid slots are ignored, set beats clear.
    valid_in = 1'b1; mode_in = 1'b0; a_in = 12'd3328; b_in = 12'd3328; twiddle = 12'd3328;
    tick();
    check("err_qm1", 32'(range_err), 0);
    valid_in = 1'b0; b_in = 12'd3329;
    tick();
    check("err_invalid_slot", 32'(range_err), 0);
    valid_in = 1'b1;
    tick();
    check("err_set", 32'(range_err), 1);
    valid_in = 1'b0; b_in = 12'd0;
    tick();
    check("err_sticky", 32'(range_err), 1);
    clr_err = 1'b1;
    tick();
    check("err_clear", 32'(range_err), 0);
    valid_in = 1'b1; twiddle = 12'd4000;
    tick();
    check("err_set_wins", 32'(range_err), 1);
    valid_in = 1'b0; clr_err = 1'b0; twiddle = 12'd0;
    repeat (L) tick();

    // Reset with 3 samples in flight.
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; mode_in = i[0]; tag_in = 8'(i);
      a_in = 12'(sa[i]); b_in = 12'(sb[i]); twiddle = 12'(sw[i]);
      tick();
    end
    valid_in = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_err", 32'(range_err), 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_no_stale", 32'({valid_out, busy}), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
